conv_window_reader: RTL and testbench
=====================================

Name: conv_window_reader

Overview:
- Read-side controller for the ping-pong image buffer pair (two DataBuf banks) that feeds the convolution core.
- Waits for the writer to mark a bank full, then scans every KERNEL x KERNEL window of the image at stride 1.
- For each window it issues PORT_NUM parallel read addresses, captures the returned pixels and presents them to the conv core with a valid/ready handshake.
- When the frame is finished it releases the bank back to the writer and moves to the other bank.

Parameters:
- WIDTH, 16, pixel data width.
- ADDR_WIDTH, 16, buffer address width; IMG_W*IMG_H must be <= 2**ADDR_WIDTH (elaboration-time check).
- KERNEL, 5, window edge length.
- PORT_NUM, 25, read ports; must equal KERNEL*KERNEL (elaboration-time check).
- IMG_W, 32, image width in pixels.
- IMG_H, 32, image height in pixels.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- bank_full  input  2  bit i high means bank i holds a complete frame; the writer holds it until bank_release[i].
- bank_release  output  2  one-cycle pulse on bit i when bank i has been fully consumed.
- rd_bank_sel  output  1  bank currently being read; steers the read mux.
- rd_en  output  1  read strobe to the selected bank.
- rd_addr_NP  output  PORT_NUM*ADDR_WIDTH  window addresses; port k in bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data_NP  input  PORT_NUM*WIDTH  read data, valid exactly 1 cycle after rd_en.
- win_valid  output  1  win_data holds a complete window.
- win_ready  input  1  conv core accepts the window.
- win_data  output  PORT_NUM*WIDTH  captured window, same port order as rd_addr_NP.
- win_row  output  ADDR_WIDTH  output-map row of the presented window.
- win_col  output  ADDR_WIDTH  output-map column of the presented window.
- frame_done  output  1  one-cycle pulse, coincident with bank_release.

Behaviour:
- Derived sizes: OUT_W = IMG_W-KERNEL+1, OUT_H = IMG_H-KERNEL+1.
- Port k has kr = k / KERNEL and kc = k % KERNEL (row-major order).
- Address of port k = (row+kr)*IMG_W + (col+kc), computed at ADDR_WIDTH bits with no overflow by the size check.
- Reset values: all outputs 0; internal bank pointer cur = 0; row = col = 0; state IDLE.
- IDLE: when bank_full[cur] = 1, go to ISSUE. bank_full[!cur] is ignored.
- ISSUE: rd_en = 1 for exactly one cycle, with rd_addr_NP for (row,col) and rd_bank_sel = cur; next state WAIT.
- rd_addr_NP is driven from the row/col registers in every state; rd_en is high only in ISSUE.
- WAIT: capture rd_data_NP into win_data; next state PRESENT.
- PRESENT: win_valid = 1.
  - win_data, win_row and win_col stay stable until win_valid && win_ready.
  - No rd_en is issued while waiting.
- On acceptance, not the last window: col++; if col was OUT_W-1, set col = 0 and row++. Next state ISSUE.
- On acceptance of the last window (row = OUT_H-1, col = OUT_W-1): next state RELEASE.
- RELEASE, single cycle: bank_release[cur] = 1 and frame_done = 1; row and col clear; cur toggles; next state IDLE.
- Latency and throughput:
  - First rd_en occurs 1 cycle after bank_full[cur] is sampled high in IDLE.
  - win_valid rises 2 cycles after rd_en.
  - Minimum 3 cycles per window.
- Simultaneous events:
  - bank_full = 2'b11: frames are processed in cur order, back to back, with one IDLE cycle between them.
  - bank_full[cur] dropping mid-frame is a writer protocol violation; the block ignores it and completes the frame.
- win_ready while win_valid = 0 is ignored.
- Reset mid-frame returns every output and state register to its reset value immediately; no bank_release pulse is produced.

Decomposition:
- Shared package cnn_buf_pkg holds:
  - OUT_W/OUT_H derivation functions;
  - the state encoding (IDLE, ISSUE, WAIT, PRESENT, RELEASE);
  - the function win_addr(row, col, k).
- One sub-module, win_addr_gen: combinational, maps row/col to the PORT_NUM packed addresses. The FSM and counters stay in the top.

Test Plan (IMG_W=IMG_H=8, KERNEL=3, PORT_NUM=9, each bank word = its own address):
- Reset: hold rst_n=0 -> all outputs 0; after release with bank_full=0 for 10 cycles -> rd_en never asserts.
- First window: bank_full=01 -> rd_en 1 cycle later with rd_bank_sel=0; win_valid 2 cycles after rd_en; win_data ports = 0,1,2,8,9,10,16,17,18; win_row=win_col=0.
- Backpressure: win_ready=0 for 5 cycles while win_valid=1 -> win_data, win_row and win_col unchanged; no rd_en; accept -> next window (0,1) with port0 = 1.
- Full frame: win_ready=1 throughout -> exactly 36 windows; last is (5,5) with port0 = 45 and port8 = 63; then bank_release=01 and frame_done for 1 cycle; then rd_bank_sel=1.
- Ping-pong: bank_full=11 -> two 36-window frames; bank_release pulses 01, then 10; second frame reads via rd_bank_sel=1.
- Mid-frame reset: assert rst_n=0 at the 10th window -> outputs 0, no release pulse; after reset, the first window is (0,0) from bank 0.

Source files
------------

// File: rtl/cnn_buf_pkg.sv
// Shared definitions for the conv window reader: output-map sizing, FSM encoding, window addressing.
// Latency: n/a (package).
// Backpressure: n/a (package).
package cnn_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_RELEASE = 3'd4
    } rd_state_t;

    // Number of window positions along the image width at stride 1.
    function automatic int unsigned out_w(input int unsigned img_w, input int unsigned kernel);
        return img_w - kernel + 1;
    endfunction

    // Number of window positions along the image height at stride 1.
    function automatic int unsigned out_h(input int unsigned img_h, input int unsigned kernel);
        return img_h - kernel + 1;
    endfunction

    // Linear buffer address of port k of the window whose top-left pixel is (row, col).
    // Ports are row-major inside the window.
    function automatic logic [31:0] win_addr(input logic [31:0] row, input logic [31:0] col,
                                             input int unsigned k, input int unsigned kernel,
                                             input int unsigned img_w);
        int unsigned kr;
        int unsigned kc;
        kr = k / kernel;
        kc = k % kernel;
        return (row + kr) * img_w + (col + kc);
    endfunction

endpackage

// File: rtl/conv_window_reader_win_addr_gen.sv
// Maps a window position (row, col) to the packed per-port buffer addresses.
// Latency: purely combinational.
// Backpressure: none; output follows row/col.
module win_addr_gen
    import cnn_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int KERNEL     = 5,
    parameter int PORT_NUM   = 25,
    parameter int IMG_W      = 32
) (
    input  logic [ADDR_WIDTH-1:0]          row,
    input  logic [ADDR_WIDTH-1:0]          col,
    output logic [PORT_NUM*ADDR_WIDTH-1:0] addr_np
);

    for (genvar k = 0; k < PORT_NUM; k++) begin : g_port
        assign addr_np[k*ADDR_WIDTH +: ADDR_WIDTH] =
            ADDR_WIDTH'(win_addr(32'(row), 32'(col), k, KERNEL, IMG_W));
    end

endmodule

// File: rtl/conv_window_reader.sv
// Read-side controller: scans every KERNEL x KERNEL window of a full ping-pong bank for the conv core.
// Latency: rd_en 1 cycle after bank_full[cur] seen in IDLE, win_valid 2 cycles after rd_en; >= 3 cycles/window.
// Backpressure: a presented window holds data/row/col stable and issues no read until win_ready.
module conv_window_reader
    import cnn_buf_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int KERNEL     = 5,
    parameter int PORT_NUM   = 25,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    bank_full,
    output logic [1:0]                    bank_release,
    output logic                          rd_bank_sel,
    output logic                          rd_en,
    output logic [PORT_NUM*ADDR_WIDTH-1:0] rd_addr_NP,
    input  logic [PORT_NUM*WIDTH-1:0]     rd_data_NP,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [PORT_NUM*WIDTH-1:0]     win_data,
    output logic [ADDR_WIDTH-1:0]         win_row,
    output logic [ADDR_WIDTH-1:0]         win_col,
    output logic                          frame_done
);

    if (PORT_NUM != KERNEL * KERNEL) begin : g_bad_port_num
        $error("conv_window_reader: PORT_NUM must equal KERNEL*KERNEL");
    end
    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_img_size
        $error("conv_window_reader: IMG_W*IMG_H does not fit in ADDR_WIDTH");
    end

    localparam int unsigned OUT_W = out_w(IMG_W, KERNEL);
    localparam int unsigned OUT_H = out_h(IMG_H, KERNEL);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(OUT_W - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(OUT_H - 1);

    rd_state_t               state, state_nxt;
    logic                    cur, cur_nxt;
    logic [ADDR_WIDTH-1:0]   row, row_nxt;
    logic [ADDR_WIDTH-1:0]   col, col_nxt;
    logic                    capture;
    logic [PORT_NUM*ADDR_WIDTH-1:0] addr_nxt;

    // Addresses are generated from the next position and registered, so rd_addr_NP always
    // matches the row/col registers while still coming out of reset as zero.
    win_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .KERNEL     (KERNEL),
        .PORT_NUM   (PORT_NUM),
        .IMG_W      (IMG_W)
    ) u_addr_gen (
        .row     (row_nxt),
        .col     (col_nxt),
        .addr_np (addr_nxt)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bank pointer and window position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= 1'b0;
            row <= '0;
            col <= '0;
        end else begin
            cur <= cur_nxt;
            row <= row_nxt;
            col <= col_nxt;
        end
    end

    // Read address register, tracks the window position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_NP <= '0;
        end else begin
            rd_addr_NP <= addr_nxt;
        end
    end

    // Window capture in the cycle the bank returns data for the last read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_data <= '0;
        end else if (capture) begin
            win_data <= rd_data_NP;
        end
    end

    // Next-state, position update and strobes
    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur;
        row_nxt      = row;
        col_nxt      = col;
        capture      = 1'b0;
        rd_en        = 1'b0;
        win_valid    = 1'b0;
        bank_release = 2'b00;
        frame_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Only the bank we own next matters; the other bank waits its turn.
                if (bank_full[cur]) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_en     = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                capture   = 1'b1;
                state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    if (row == LAST_ROW && col == LAST_COL) begin
                        state_nxt = ST_RELEASE;
                    end else begin
                        state_nxt = ST_ISSUE;
                        if (col == LAST_COL) begin
                            col_nxt = '0;
                            row_nxt = row + 1'b1;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                bank_release = cur ? 2'b10 : 2'b01;
                frame_done   = 1'b1;
                row_nxt      = '0;
                col_nxt      = '0;
                cur_nxt      = ~cur;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rd_bank_sel = cur;
    assign win_row     = row;
    assign win_col     = col;

endmodule

// File: tb/tb_conv_window_reader.sv
// Self-checking bench for conv_window_reader on an 8x8 image with a 3x3 kernel.
// Latency: n/a (testbench).
// Backpressure: win_ready driven by hand-written sequences and randomly.
module tb_conv_window_reader;

    localparam int WIDTH = 16;
    localparam int AW    = 16;
    localparam int K     = 3;
    localparam int PN    = 9;
    localparam int IW    = 8;
    localparam int IH    = 8;
    localparam int OW    = IW - K + 1;
    localparam int OH    = IH - K + 1;
    localparam int NWIN  = OW * OH;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         bank_full = 2'b00;
    logic [1:0]         bank_release;
    logic               rd_bank_sel;
    logic               rd_en;
    logic [PN*AW-1:0]   rd_addr_NP;
    logic [PN*WIDTH-1:0] rd_data_NP;
    logic               win_valid;
    logic               win_ready = 1'b0;
    logic [PN*WIDTH-1:0] win_data;
    logic [AW-1:0]      win_row;
    logic [AW-1:0]      win_col;
    logic               frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_window_reader #(
        .WIDTH(WIDTH), .ADDR_WIDTH(AW), .KERNEL(K), .PORT_NUM(PN), .IMG_W(IW), .IMG_H(IH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .rd_bank_sel  (rd_bank_sel),
        .rd_en        (rd_en),
        .rd_addr_NP   (rd_addr_NP),
        .rd_data_NP   (rd_data_NP),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_data     (win_data),
        .win_row      (win_row),
        .win_col      (win_col),
        .frame_done   (frame_done)
    );

    // Bank model: each word holds its own address, returned one cycle after rd_en.
    // Without a read the bus carries junk so a mistimed capture is visible.
    always @(posedge clk) begin
        for (int k = 0; k < PN; k++) begin
            rd_data_NP[k*WIDTH +: WIDTH] <= rd_en ? WIDTH'(rd_addr_NP[k*AW +: AW]) : WIDTH'($urandom);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Expected packed addresses (== pixel values) of window number w in row-major scan order.
    function automatic logic [PN*AW-1:0] exp_pack(input int w);
        logic [PN*AW-1:0] v;
        int r, c;
        r = w / OW;
        c = w % OW;
        for (int k = 0; k < PN; k++) v[k*AW +: AW] = AW'((r + k / K) * IW + c + k % K);
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_release"}, bank_release, 0);
        chk({tag, "_bank_sel"}, rd_bank_sel, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr_NP, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_win_data"}, win_data, 0);
        chk({tag, "_win_row"}, win_row, 0);
        chk({tag, "_win_col"}, win_col, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // ---------------- reference model (window-sequence level) ----------------
    int exp_bank, widx, frames, rd_age;
    bit outstanding, rel_due;

    task automatic model_reset();
        exp_bank = 0; widx = 0; frames = 0; rd_age = -1; outstanding = 0; rel_due = 0;
    endtask

    // Called just after a falling edge: check what is visible, then drive win_ready for the next edge.
    task automatic model_cycle(input bit ready_now);
        bit acc;
        if (rel_due) begin
            chk("release_bits", bank_release, 2'b01 << exp_bank);
            chk("release_done", frame_done, 1);
            rel_due = 0;
            bank_full[exp_bank] = 1'b0;
            exp_bank ^= 1;
            widx = 0;
            frames++;
        end else begin
            chk("no_release", {bank_release, frame_done}, 0);
        end
        if (rd_en) begin
            chk("rd_once", outstanding, 0);
            chk("rd_bank", rd_bank_sel, exp_bank);
            chk("rd_addr", rd_addr_NP, exp_pack(widx));
            outstanding = 1;
            rd_age = 0;
        end
        if (rd_age == 2) chk("valid_latency", win_valid, 1);
        acc = 0;
        if (win_valid) begin
            chk("valid_after_read", outstanding, 1);
            chk("win_data", win_data, exp_pack(widx));
            chk("win_row", win_row, widx / OW);
            chk("win_col", win_col, widx % OW);
            acc = ready_now;
        end
        if (acc) begin
            outstanding = 0;
            rd_age = -1;
            widx++;
            if (widx == NWIN) rel_due = 1;
        end else if (rd_age >= 0 && rd_age < 100) begin
            rd_age++;
        end
        win_ready = ready_now;
    endtask

    // Run until frames_target frames complete, or until window stop_win is presented (stop_win >= 0).
    task automatic run_model(input int frames_target, input int stop_win, input int ready_pct);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (stop_win >= 0 && win_valid && widx == stop_win) begin
                model_cycle(1'b0);
                return;
            end
            model_cycle($urandom_range(0, 99) < ready_pct);
            if (frames >= frames_target) return;
        end
        fail_now("run_model");
    endtask

    // Accept the presented window and wait for the next one; release must not appear meanwhile.
    task automatic accept_and_wait(output bit ok);
        ok = 0;
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (frame_done) begin
                chk("early_release", frame_done, 0);
                return;
            end
            if (win_valid) begin
                ok = 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int idx;
        int row;
        int col;
        int p0;
        int p8;
    } win_vec_t;

    win_vec_t vecs[5];
    logic [PN*WIDTH-1:0] first_win;
    int cur_w;
    bit ok;

    initial begin
        vecs[0] = '{1, 0, 1, 1, 19};
        vecs[1] = '{5, 0, 5, 5, 23};
        vecs[2] = '{6, 1, 0, 8, 26};
        vecs[3] = '{20, 3, 2, 26, 44};
        vecs[4] = '{35, 5, 5, 45, 63};
        first_win = {16'd18, 16'd17, 16'd16, 16'd10, 16'd9, 16'd8, 16'd2, 16'd1, 16'd0};

        // Reset: outputs zero, then idle with no full bank.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_rd_en", rd_en, 0);
            chk("idle_valid", win_valid, 0);
        end

        // First window.
        bank_full = 2'b01;
        @(negedge clk);
        chk("first_rd_en", rd_en, 1);
        chk("first_bank", rd_bank_sel, 0);
        chk("first_addr", rd_addr_NP, first_win);
        @(negedge clk);
        chk("first_wait_rd_en", rd_en, 0);
        chk("first_wait_valid", win_valid, 0);
        @(negedge clk);
        chk("first_valid", win_valid, 1);
        chk("first_data", win_data, first_win);
        chk("first_row", win_row, 0);
        chk("first_col", win_col, 0);

        // Backpressure: window held, no reads.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", win_valid, 1);
            chk("bp_rd_en", rd_en, 0);
            chk("bp_data", win_data, first_win);
            chk("bp_row", win_row, 0);
            chk("bp_col", win_col, 0);
        end
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
        chk("bp_next_rd_en", rd_en, 1);
        chk("bp_next_addr0", rd_addr_NP[AW-1:0], 1);
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_valid", win_valid, 1);
        chk("bp_next_col", win_col, 1);
        chk("bp_next_data0", win_data[WIDTH-1:0], 1);
        cur_w = 1;

        // Full frame, table-driven checkpoints.
        for (int v = 0; v < 5; v++) begin
            while (cur_w < vecs[v].idx) begin
                accept_and_wait(ok);
                if (!ok) begin
                    fail_now("frame_advance");
                    break;
                end
                cur_w++;
            end
            chk("tbl_row", win_row, vecs[v].row);
            chk("tbl_col", win_col, vecs[v].col);
            chk("tbl_port0", win_data[WIDTH-1:0], vecs[v].p0);
            chk("tbl_port8", win_data[8*WIDTH +: WIDTH], vecs[v].p8);
        end
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
        chk("frame_release", bank_release, 2'b01);
        chk("frame_done", frame_done, 1);
        bank_full = 2'b00;
        @(negedge clk);
        chk("release_pulse_end", {bank_release, frame_done}, 0);
        chk("after_frame_bank", rd_bank_sel, 1);
        chk("after_frame_idle", rd_en, 0);

        // Ping-pong with random backpressure, both banks full.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bank_full = 2'b11;
        run_model(2, -1, 70);
        chk("pingpong_frames", frames, 2);
        bank_full = 2'b00;

        // Mid-frame reset at the 10th window.
        model_reset();
        bank_full = 2'b01;
        run_model(1, 9, 60);
        chk("midreset_reached", widx, 9);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        chk("midreset_no_release", {bank_release, frame_done}, 0);
        rst_n = 1'b1;
        model_reset();
        run_model(1, 0, 100);
        chk("midreset_first_row", win_row, 0);
        chk("midreset_first_col", win_col, 0);
        chk("midreset_first_valid", win_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
